// File: rtl/instruction_queue_if.sv
// Fetch-side and decode-side signals of the instruction queue.
// The master modport is the fetcher/dispatch environment; the slave modport is the queue.
interface instruction_queue_if;
    logic        rdy_in;
    logic        clear_in;
    logic        if_valid_in;
    logic [31:0] if_inst_in;
    logic [31:0] if_pc_in;
    logic        if_full_out;
    logic        dec_valid_out;
    logic [31:0] dec_inst_out;
    logic [31:0] dec_pc_out;
    logic        stall_in;

    modport slave (
        input  rdy_in, clear_in, if_valid_in, if_inst_in, if_pc_in, stall_in,
        output if_full_out, dec_valid_out, dec_inst_out, dec_pc_out
    );

    modport master (
        output rdy_in, clear_in, if_valid_in, if_inst_in, if_pc_in, stall_in,
        input  if_full_out, dec_valid_out, dec_inst_out, dec_pc_out
    );
endinterface

// File: rtl/instruction_queue.sv
// Circular instruction FIFO between the fetcher and the decoder; oldest entry is
// presented combinationally and popped when downstream is not stalled.
module instruction_queue #(
    parameter int QUEUE_SIZE_LOG = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    instruction_queue_if.slave q
);
    localparam int PTR_W = QUEUE_SIZE_LOG;
    localparam int CNT_W = QUEUE_SIZE_LOG + 1;
    localparam int N     = 1 << QUEUE_SIZE_LOG;
    localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t           mem [N];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic   empty, full, pop, push;
    entry_t head_entry;

    always_comb begin
        empty      = (count == '0);
        full       = (count == DEPTH);
        // A pop frees a slot in the same edge, so a full queue still accepts a push alongside it.
        pop        = q.rdy_in & ~q.clear_in & ~empty & ~q.stall_in;
        push       = q.rdy_in & ~q.clear_in & q.if_valid_in & (~full | pop);
        head_entry = mem[head];
    end

    assign q.if_full_out   = full;
    assign q.dec_valid_out = ~empty;
    assign q.dec_inst_out  = empty ? 32'h0 : head_entry.inst;
    assign q.dec_pc_out    = empty ? 32'h0 : head_entry.pc;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.rdy_in) begin
            if (q.clear_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop)  head <= head + PTR_ONE;
                if (push) tail <= tail + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is never reset; validity is carried entirely by count.
    always_ff @(posedge clk_in) begin
        if (push) mem[tail] <= '{inst: q.if_inst_in, pc: q.if_pc_in};
    end
endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: vector table plus multi-cycle sequences
// and a scoreboard-checked random-stall stream.
module tb_instruction_queue;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    instruction_queue_if bus ();
    instruction_queue #(.QUEUE_SIZE_LOG(4)) dut (.clk_in(clk), .rst_in(rst), .q(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, clr, vld;
        logic [31:0] inst, pc;
        logic        stall;
        logic        e_vld, e_full;
        logic [31:0] e_inst, e_pc;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return 32'hC0DE_0000 + pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic stall);
        bus.rdy_in = 1'b1; bus.clear_in = 1'b0; bus.if_valid_in = 1'b0; bus.stall_in = stall;
    endtask

    task automatic push_cyc(input logic [31:0] pc, input logic stall);
        bus.if_valid_in = 1'b1; bus.if_inst_in = mk_inst(pc); bus.if_pc_in = pc; bus.stall_in = stall;
        step();
        bus.if_valid_in = 1'b0;
    endtask

    task automatic expect_head(input string name, input logic [31:0] pc);
        chk({name, "_vld"}, {31'h0, bus.dec_valid_out}, 32'h1);
        chk({name, "_pc"}, bus.dec_pc_out, pc);
        chk({name, "_inst"}, bus.dec_inst_out, mk_inst(pc));
    endtask

    task automatic expect_empty(input string name);
        chk({name, "_vld"}, {31'h0, bus.dec_valid_out}, 32'h0);
        chk({name, "_full"}, {31'h0, bus.if_full_out}, 32'h0);
        chk({name, "_pc"}, bus.dec_pc_out, 32'h0);
        chk({name, "_inst"}, bus.dec_inst_out, 32'h0);
    endtask

    initial begin
        logic [31:0] model [$];
        int pushed, popped, cyc;
        logic m_pop, m_push;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 32'h4,    1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,    1'b0, 1'b1, 1'b0, 32'hAAAA_0001, 32'h4};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'hBBBB_0002, 32'h8,    1'b0, 1'b1, 1'b0, 32'hAAAA_0001, 32'h4};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'hBBBB_0002, 32'h8,    1'b0, 1'b1, 1'b0, 32'hBBBB_0002, 32'h8};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,    1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'hCCCC_0003, 32'hC,    1'b0, 1'b1, 1'b0, 32'hCCCC_0003, 32'hC};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'hDDDD_0004, 32'h10,   1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 32'hEEEE_0005, 32'h14,   1'b1, 1'b1, 1'b0, 32'hEEEE_0005, 32'h14};

        rst = 1'b1;
        bus.if_inst_in = '0; bus.if_pc_in = '0;
        idle(1'b0);
        #2;
        expect_empty("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven single-edge vectors
        for (int i = 0; i < 9; i++) begin
            bus.rdy_in = vecs[i].rdy; bus.clear_in = vecs[i].clr; bus.if_valid_in = vecs[i].vld;
            bus.if_inst_in = vecs[i].inst; bus.if_pc_in = vecs[i].pc; bus.stall_in = vecs[i].stall;
            step();
            chk($sformatf("vec%0d_vld", i), {31'h0, bus.dec_valid_out}, {31'h0, vecs[i].e_vld});
            chk($sformatf("vec%0d_full", i), {31'h0, bus.if_full_out}, {31'h0, vecs[i].e_full});
            chk($sformatf("vec%0d_inst", i), bus.dec_inst_out, vecs[i].e_inst);
            chk($sformatf("vec%0d_pc", i), bus.dec_pc_out, vecs[i].e_pc);
        end

        // Asynchronous reset with a non-empty queue takes effect without an edge
        idle(1'b1);
        rst = 1'b1;
        #1;
        expect_empty("async_rst");
        #1;
        rst = 1'b0;
        step();
        expect_empty("post_rst");

        // Fill to 16, drop a 17th push, then push+pop on full, drain through the wrap
        for (int i = 0; i < 16; i++) begin
            push_cyc(32'(i * 4), 1'b1);
            if (i == 14) chk("fill15_full", {31'h0, bus.if_full_out}, 32'h0);
        end
        chk("fill16_full", {31'h0, bus.if_full_out}, 32'h1);
        push_cyc(32'h999, 1'b1);
        chk("drop17_full", {31'h0, bus.if_full_out}, 32'h1);
        expect_head("drop17", 32'h0);
        push_cyc(32'h40, 1'b0);
        chk("swap_full", {31'h0, bus.if_full_out}, 32'h1);
        expect_head("swap", 32'h4);
        idle(1'b0);
        for (int i = 1; i <= 16; i++) begin
            expect_head($sformatf("drain%0d", i), 32'(i * 4));
            step();
        end
        expect_empty("drained");

        // Clear beats a simultaneous push; next push lands as head
        for (int i = 0; i < 5; i++) push_cyc(32'h80 + 32'(i * 4), 1'b1);
        expect_head("pre_clear", 32'h80);
        bus.clear_in = 1'b1;
        push_cyc(32'h100, 1'b0);
        bus.clear_in = 1'b0;
        expect_empty("clear");
        push_cyc(32'h200, 1'b1);
        expect_head("after_clear", 32'h200);
        idle(1'b0);
        step();
        expect_empty("clear_no_ghost");

        // rdy_in low freezes everything, then one push and one pop per edge
        for (int i = 0; i < 3; i++) push_cyc(32'h300 + 32'(i * 4), 1'b1);
        bus.rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cyc(32'h3F0, 1'b0);
            expect_head($sformatf("frozen%0d", i), 32'h300);
        end
        bus.rdy_in = 1'b1;
        push_cyc(32'h30C, 1'b0);
        expect_head("thaw0", 32'h304);
        push_cyc(32'h310, 1'b0);
        expect_head("thaw1", 32'h308);
        idle(1'b0);
        step();
        expect_head("thaw_d0", 32'h30C);
        step();
        expect_head("thaw_d1", 32'h310);
        step();
        expect_empty("thaw_empty");

        // Random stall stream checked against a queue model
        pushed = 0; popped = 0; cyc = 0;
        while ((pushed < 40 || model.size() > 0) && cyc < 1000) begin
            bus.stall_in    = 1'($urandom_range(0, 1));
            bus.if_valid_in = (pushed < 40) && (model.size() < 16) && ($urandom_range(0, 3) != 0);
            bus.if_pc_in    = 32'h1000 + 32'(pushed * 4);
            bus.if_inst_in  = mk_inst(bus.if_pc_in);
            chk("rnd_full", {31'h0, bus.if_full_out}, {31'h0, model.size() == 16});
            if (model.size() > 0) expect_head("rnd", model[0]);
            else expect_empty("rnd_empty");
            m_pop  = (model.size() > 0) && !bus.stall_in;
            m_push = bus.if_valid_in;
            step();
            if (m_pop) begin void'(model.pop_front()); popped++; end
            if (m_push) begin model.push_back(32'h1000 + 32'(pushed * 4)); pushed++; end
            cyc++;
        end
        chk("rnd_budget", 32'(cyc < 1000), 32'h1);
        chk("rnd_popped", 32'(popped), 32'd40);
        idle(1'b0);
        expect_empty("rnd_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
